dist_argmin_accum: RTL and testbench

- Sits directly downstream of the euclidean distance stage in the compute node.
- Consumes a stream of per-template distances, one beat per (frame, template) pair.
- Accumulates each template's distance across all frames of an utterance.
- At utterance end, scans the accumulators for the minimum and emits the best-matching template id and score to the result/host interface.

---
 rtl/dist_argmin_accum.sv | 139 +++++++++++++
 tb/tb_dist_argmin_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dist_argmin_accum.sv
// Per-template distance accumulator with utterance-end argmin scan.
// Accumulates saturating sums per template, then scans for the lowest score and holds it for the host.
module dist_argmin_accum #(
  parameter int DIST_W        = 32,
  parameter int ACC_W         = 40,
  parameter int NUM_TEMPLATES = 16,
  parameter int ID_W          = 4,
  parameter int FRM_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIST_W-1:0] in_dist,
  input  logic [ID_W-1:0]   in_tmpl,
  input  logic              in_last_tmpl,
  input  logic              in_last_frame,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_best_id,
  output logic [ACC_W-1:0]  out_best_score,
  output logic [FRM_W-1:0]  out_frames,
  output logic              out_none,
  output logic              sat_flag,
  output logic              busy
);

  localparam logic [1:0]      ST_ACCUM  = 2'd0;
  localparam logic [1:0]      ST_SCAN   = 2'd1;
  localparam logic [1:0]      ST_RESULT = 2'd2;
  localparam logic [ID_W:0]   SCAN_END  = (ID_W+1)'(NUM_TEMPLATES);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  // Returns {overflow, value}; value clamps to the accumulator maximum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [DIST_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    if (s[ACC_W]) s = {1'b1, ACC_MAX};
    return s;
  endfunction

  logic [1:0]               state;
  logic [ACC_W-1:0]         acc [NUM_TEMPLATES];
  logic [NUM_TEMPLATES-1:0] vld;
  logic [FRM_W-1:0]         frame_cnt;
  logic [ID_W:0]            scan_cnt;
  logic                     best_found;
  logic                     accept;
  logic [ACC_W:0]           upd_p0;
  logic [ACC_W-1:0]         new_acc_p0;
  logic                     ovf_p0;
  logic [ACC_W-1:0]         cand_acc_p1;
  logic [ID_W-1:0]          cand_id_p1;
  logic                     vld_p1;
  logic                     take_p1;

  assign in_ready   = (state == ST_ACCUM);
  assign out_valid  = (state == ST_RESULT);
  assign busy       = (state == ST_SCAN) || (state == ST_RESULT);
  assign out_frames = frame_cnt;
  assign accept     = in_valid && in_ready;

  // Stage p0: read-modify-write of the addressed accumulator in the accept cycle,
  // so a beat to the same template on the next cycle already sees this sum.
  assign upd_p0     = sat_add(acc[in_tmpl], in_dist);
  assign new_acc_p0 = vld[in_tmpl] ? upd_p0[ACC_W-1:0] : ACC_W'(in_dist);
  assign ovf_p0     = vld[in_tmpl] && upd_p0[ACC_W];

  // Stage p1: compare the candidate fetched last scan cycle against the running best.
  assign take_p1 = vld_p1 && (!best_found || (cand_acc_p1 < out_best_score));

  always_ff @(posedge clock) begin
    if (accept) acc[in_tmpl] <= new_acc_p0;
    cand_acc_p1 <= acc[scan_cnt[ID_W-1:0]];
    cand_id_p1  <= scan_cnt[ID_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_ACCUM;
      vld            <= '0;
      frame_cnt      <= '0;
      sat_flag       <= 1'b0;
      scan_cnt       <= '0;
      vld_p1         <= 1'b0;
      best_found     <= 1'b0;
      out_best_id    <= '0;
      out_best_score <= '0;
      out_none       <= 1'b0;
    end else begin
      vld_p1 <= (state == ST_SCAN) && (scan_cnt != SCAN_END) && vld[scan_cnt[ID_W-1:0]];
      if (take_p1) begin
        best_found     <= 1'b1;
        out_best_id    <= cand_id_p1;
        out_best_score <= cand_acc_p1;
      end
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            vld[in_tmpl] <= 1'b1;
            if (ovf_p0) sat_flag <= 1'b1;
            if (in_last_tmpl) begin
              if (frame_cnt != {FRM_W{1'b1}}) frame_cnt <= frame_cnt + 1'b1;
              if (in_last_frame) begin
                state      <= ST_SCAN;
                scan_cnt   <= '0;
                best_found <= 1'b0;
              end
            end
          end
        end
        ST_SCAN: begin
          if (scan_cnt != SCAN_END) begin
            scan_cnt <= scan_cnt + 1'b1;
          end else begin
            state <= ST_RESULT;
            if (!best_found && !take_p1) begin
              out_none       <= 1'b1;
              out_best_id    <= '0;
              out_best_score <= ACC_MAX;
            end
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            state     <= ST_ACCUM;
            vld       <= '0;
            frame_cnt <= '0;
            sat_flag  <= 1'b0;
            out_none  <= 1'b0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_argmin_accum.sv
// Bench for dist_argmin_accum: directed and random utterances checked against an array-based model.
module tb_dist_argmin_accum;
  localparam int DIST_W = 32, ACC_W = 40, NT = 16, ID_W = 4, FRM_W = 16;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DIST_W-1:0] in_dist = '0;
  logic [ID_W-1:0]   in_tmpl = '0;
  logic              in_last_tmpl = 1'b0;
  logic              in_last_frame = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ID_W-1:0]   out_best_id;
  logic [ACC_W-1:0]  out_best_score;
  logic [FRM_W-1:0]  out_frames;
  logic              out_none;
  logic              sat_flag;
  logic              busy;

  int errors = 0;
  int checks = 0;

  longint unsigned m_acc [NT];
  bit              m_vld [NT];
  int              m_frames;
  bit              m_sat;

  dist_argmin_accum #(.DIST_W(DIST_W), .ACC_W(ACC_W), .NUM_TEMPLATES(NT), .ID_W(ID_W), .FRM_W(FRM_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
    .in_tmpl(in_tmpl), .in_last_tmpl(in_last_tmpl), .in_last_frame(in_last_frame),
    .out_valid(out_valid), .out_ready(out_ready), .out_best_id(out_best_id),
    .out_best_score(out_best_score), .out_frames(out_frames), .out_none(out_none),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      m_acc[i] = 0;
      m_vld[i] = 1'b0;
    end
    m_frames = 0;
    m_sat    = 1'b0;
  endtask

  task automatic model_beat(input int t, input longint unsigned d, input bit lt);
    longint unsigned s;
    if (!m_vld[t]) begin
      m_acc[t] = d;
      m_vld[t] = 1'b1;
    end else begin
      s = m_acc[t] + d;
      if (s > ACC_MAX) begin
        s     = ACC_MAX;
        m_sat = 1'b1;
      end
      m_acc[t] = s;
    end
    if (lt && m_frames < 65535) m_frames++;
  endtask

  // One beat per call; consecutive calls give back-to-back beats with no bubble.
  task automatic beat(input int t, input logic [31:0] d, input bit lt, input bit lf, input bit check_ready);
    if (check_ready) chk("in_ready_on_beat", in_ready, 1);
    in_valid      = 1'b1;
    in_tmpl       = 4'(t);
    in_dist       = d;
    in_last_tmpl  = lt;
    in_last_frame = lf;
    @(negedge clock);
    in_valid      = 1'b0;
    in_last_tmpl  = 1'b0;
    in_last_frame = 1'b0;
    model_beat(t, longint'(d), lt);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, out_valid, 0);
    chk({tag, "_hs_ready"}, in_ready, 1);
    chk({tag, "_hs_state"}, {busy, sat_flag, out_none, out_frames}, 0);
    model_clear();
  endtask

  // Called right after the final beat; checks latency, result fields and hold stability.
  task automatic finish_utt(input string tag, input int hold);
    int cyc;
    int bad;
    bit found;
    int exp_id;
    longint unsigned exp_sc;
    logic [63:0] snap;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, NT + 1);
    found  = 1'b0;
    exp_id = 0;
    exp_sc = ACC_MAX;
    for (int i = 0; i < NT; i++) begin
      if (m_vld[i] && (!found || m_acc[i] < exp_sc)) begin
        found  = 1'b1;
        exp_id = i;
        exp_sc = m_acc[i];
      end
    end
    chk({tag, "_busy_ready"}, {busy, in_ready}, 2'b10);
    chk({tag, "_id"}, out_best_id, exp_id);
    chk({tag, "_score"}, out_best_score, exp_sc);
    chk({tag, "_frames"}, out_frames, m_frames);
    chk({tag, "_none_sat"}, {out_none, sat_flag}, {!found, m_sat});
    snap = {out_best_id, out_best_score, out_frames, out_none, sat_flag};
    bad  = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if ({out_best_id, out_best_score, out_frames, out_none, sat_flag} !== snap ||
          out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk({tag, "_hold_stable"}, bad, 0);
    handshake(tag);
  endtask

  initial begin
    int nfr;
    int nb;
    int seen;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_ready_valid", {in_ready, out_valid}, 2'b10);
    chk("rst_best", {out_best_id, out_best_score}, 0);
    chk("rst_flags", {out_frames, out_none, sat_flag, busy}, 0);

    // Basic two-frame run.
    beat(0, 10, 0, 0, 1); beat(1, 20, 0, 0, 1); beat(2, 5, 0, 0, 1); beat(3, 30, 1, 0, 1);
    beat(0, 10, 0, 0, 1); beat(1, 1, 0, 0, 1);  beat(2, 9, 0, 0, 1); beat(3, 30, 1, 1, 1);
    chk("basic_model_score", m_acc[2], 14);
    finish_utt("basic", 0);

    // Equal scores resolve to the lower index regardless of arrival order.
    beat(3, 7, 0, 0, 1); beat(1, 7, 0, 0, 1); beat(0, 9, 0, 0, 1); beat(2, 9, 1, 1, 1);
    finish_utt("tie", 1);

    // Saturation: tmpl0 pinned at the maximum, tmpl1 wins.
    for (int i = 0; i < 300; i++) beat(0, 32'hFFFF_FFFF, 0, 0, 0);
    beat(1, 1, 1, 1, 1);
    chk("sat_model_acc0", m_acc[0], ACC_MAX);
    finish_utt("sat_min1", 0);

    // Saturated accumulator is itself the reported score.
    for (int i = 0; i < 260; i++) beat(0, 32'hFFFF_FFFF, 0, 0, 0);
    beat(0, 32'hFFFF_FFFF, 1, 1, 1);
    finish_utt("sat_only", 0);

    // Backpressure for 50 cycles, then a fresh utterance must not add to stale sums.
    beat(1, 50, 0, 0, 1); beat(6, 40, 1, 1, 1);
    finish_utt("backpressure", 50);
    beat(6, 3, 1, 1, 1);
    finish_utt("after_bp", 0);

    // Single-beat utterance after reset.
    reset = 1'b1; @(negedge clock); reset = 1'b0; model_clear();
    beat(5, 4, 1, 1, 1);
    finish_utt("single", 0);

    // Reset mid-scan discards the utterance.
    beat(7, 10, 1, 1, 1);
    repeat (5) @(negedge clock);
    reset = 1'b1; @(negedge clock); reset = 1'b0; model_clear();
    chk("midscan_rst_ready", {in_ready, busy, out_valid}, 3'b100);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen++;
    end
    chk("midscan_no_valid", seen, 0);
    beat(7, 5, 1, 1, 1);
    finish_utt("post_midscan", 0);

    // Reset while a result is pending drops it.
    beat(9, 2, 1, 1, 1);
    repeat (NT + 3) @(negedge clock);
    reset = 1'b1; @(negedge clock); reset = 1'b0; model_clear();
    chk("pending_rst", {out_valid, in_ready, out_frames}, {1'b0, 1'b1, 16'd0});

    // Back-to-back beats to one template.
    beat(2, 1, 0, 0, 1); beat(2, 2, 0, 0, 1); beat(2, 3, 1, 1, 1);
    finish_utt("b2b", 0);

    // Random utterances with duplicates, gaps and mixed magnitudes.
    for (int u = 0; u < 8; u++) begin
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        nb = $urandom_range(1, 6);
        for (int b = 0; b < nb; b++) begin
          beat($urandom_range(0, NT - 1),
               ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20)),
               b == nb - 1, (b == nb - 1) && (f == nfr - 1), 0);
        end
      end
      finish_utt($sformatf("rand%0d", u), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
